// File: rtl/midi_pkg.sv
// Shared MIDI definitions: parser state, channel-voice message types and the
// data-length lookup used to decide when a message is complete.
package midi_pkg;

  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2, DISCARD} state_e;

  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CTRL     = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;

  // 0 for data bytes and system traffic, else the number of data bytes that follow.
  function automatic logic [1:0] midi_data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    if (status[7] && status[7:4] != 4'hF) begin
      case (status[7:4])
        PROG, CHAN_AT: len = 2'd1;
        default:       len = 2'd2;
      endcase
    end
    return len;
  endfunction

endpackage

// File: rtl/midi_msg_parser.sv
// MIDI byte-to-message assembler with running status, real-time transparency and
// SysEx discard. Define MIDI_VEL0_NOTEOFF_EN to emit velocity-0 note-ons as note-offs.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       byte_valid,
  input  logic [7:0] rx_byte,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic       msg_err
);

  state_e     state_q, state_d;
  logic [7:0] run_status_q, run_status_d;
  logic [6:0] d1_q, d1_d;

  logic       is_data, is_chan, is_sys;
  logic [1:0] len;
  logic       complete, pass, emit, drop_err;
  logic [7:0] out_status;
  logic [6:0] out_d1, out_d2;

  // Real-time bytes (0xF8-0xFF) match none of these and so leave everything untouched.
  assign is_data = byte_valid && !rx_byte[7];
  assign is_chan = byte_valid && rx_byte[7] && (rx_byte[7:4] != 4'hF);
  assign is_sys  = byte_valid && (rx_byte[7:3] == 5'b11110);
  assign len     = midi_data_len(run_status_q);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      run_status_q <= 8'h00;
      d1_q         <= 7'h00;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      d1_q         <= d1_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    d1_d         = d1_q;
    if (is_chan) begin
      run_status_d = rx_byte;
      state_d      = WAIT_D1;
    end else if (is_sys) begin
      run_status_d = 8'h00;
      state_d      = DISCARD;
    end else if (is_data) begin
      case (state_q)
        WAIT_D1: begin
          d1_d    = rx_byte[6:0];
          state_d = (len == 2'd1) ? WAIT_D1 : WAIT_D2;
        end
        WAIT_D2: state_d = WAIT_D1;
        default: ;
      endcase
    end
  end

  always_comb begin
    complete = is_data && ((state_q == WAIT_D1 && len == 2'd1) || state_q == WAIT_D2);
    pass     = OMNI || (run_status_q[3:0] == CHANNEL);
    emit     = complete && pass;
    drop_err = (is_data && state_q == IDLE) || ((is_chan || is_sys) && state_q == WAIT_D2);

    out_status = run_status_q;
    out_d1     = (state_q == WAIT_D1) ? rx_byte[6:0] : d1_q;
    out_d2     = (state_q == WAIT_D2) ? rx_byte[6:0] : 7'h00;
`ifdef MIDI_VEL0_NOTEOFF_EN
    // Only the emitted copy is rewritten; running status stays a note-on.
    if (run_status_q[7:4] == NOTE_ON && out_d2 == 7'h00) begin
      out_status = {NOTE_OFF, run_status_q[3:0]};
      out_d2     = 7'h40;
    end
`endif
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      msg_valid  <= 1'b0;
      msg_err    <= 1'b0;
      msg_status <= 8'h00;
      msg_data1  <= 7'h00;
      msg_data2  <= 7'h00;
    end else begin
      msg_valid <= emit;
      msg_err   <= drop_err;
      if (emit) begin
        msg_status <= out_status;
        msg_data1  <= out_d1;
        msg_data2  <= out_d2;
      end
    end
  end

endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Byte-to-message assembler sitting directly downstream of the MIDI UART receiver. Consumes one received byte per strobe, tracks status and running status, and emits complete channel-voice messages (status, data1, data2) as a single-cycle strobe for the note/stepper control logic. Real-time bytes are transparent, and SysEx/system-common traffic is discarded.

## Interface
Parameters:
- `OMNI`, default 1: 1 passes all channels; 0 passes only channel `CHANNEL`.
- `CHANNEL`, default 4'd0: channel number (0–15) used when `OMNI`=0.

Ports:
- `Clk`  in  1  single system clock; all state on rising edge.
- `Rst`  in  1  reset, asynchronous, active-high.
- `byte_valid`  in  1  one-cycle strobe; `rx_byte` is valid this cycle.
- `rx_byte`  in  8  received MIDI byte.
- `msg_valid`  out  1  one-cycle strobe; message outputs are valid.
- `msg_status`  out  8  status byte of the message (type in [7:4], channel in [3:0]).
- `msg_data1`  out  7  first data byte (note, controller, program, and so on).
- `msg_data2`  out  7  second data byte; 0 for one-data-byte messages.
- `msg_err`  out  1  one-cycle strobe; a byte was dropped or a message was abandoned.

## Operation
Byte classification:
- Data byte: bit7 = 0.
- Channel status: 0x80–0xEF.
  - Length 2 for types 0x8, 0x9, 0xA, 0xB, 0xE.
  - Length 1 for types 0xC, 0xD.
- System common/SysEx: 0xF0–0xF7.
- Real-time: 0xF8–0xFF.

State machine `state`:
- **IDLE**: no running status.
  - Data byte → dropped, `msg_err`.
  - Channel status → latch `run_status`, go to WAIT_D1.
  - 0xF0–0xF7 → DISCARD.
- **WAIT_D1**
  - Data byte → latch d1.
    - Length 1 → emit, go to WAIT_D1 (running status).
    - Length 2 → go to WAIT_D2.
- **WAIT_D2**
  - Data byte → latch d2, emit, go to WAIT_D1 (running status).
- **DISCARD**
  - Data bytes → ignored, no `msg_err`.
  - Channel status → latch it, go to WAIT_D1.
  - 0xF0–0xF7 → stay in DISCARD.

Rules in every state:
- Real-time bytes are ignored with no state change, including between data bytes.
- Channel status in WAIT_D1 or WAIT_D2 → restart with the new status. If in WAIT_D2, the partial message is abandoned and `msg_err` pulses.
- 0xF0–0xF7 clears running status and goes to DISCARD; from WAIT_D2 this also pulses `msg_err`.

Emit:
- Registers `msg_status`/`msg_data1`/`msg_data2` and pulses `msg_valid`.
- Suppressed (no `msg_valid`, no `msg_err`) when `OMNI`=0 and `run_status[3:0]` ≠ `CHANNEL`. Parser state still advances normally.

Message outputs hold their last values between strobes.

## Timing
- Reset: `state`=IDLE, `run_status`=0, and every output is 0 (`msg_valid`, `msg_status`, `msg_data1`, `msg_data2`, `msg_err`).
- Reset mid-message discards the partial message and all running status.
- Latency: `msg_valid` is high exactly one clock after the cycle in which the completing `byte_valid` was sampled.
- `byte_valid` on consecutive clocks is supported at full rate. No backpressure; the consumer must accept every `msg_valid`.
- `msg_valid` and `msg_err` are never both high in the same cycle.
- `byte_valid` low → no state change, and both strobes low the next cycle.

## Configuration
- `MIDI_VEL0_NOTEOFF_EN` defined: a note-on (0x9n) with `msg_data2`=0 is emitted as note-off. `msg_status` becomes {4'h8, n} and `msg_data2`=7'h40. `run_status` is unchanged, so running-status note-ons keep working.
- Macro undefined: messages are emitted unmodified.

## Structure
- Shared package `midi_pkg`:
  - state enum (IDLE, WAIT_D1, WAIT_D2, DISCARD);
  - message-type constants (`NOTE_OFF`=4'h8, `NOTE_ON`=4'h9, `POLY_AT`=4'hA, `CTRL`=4'hB, `PROG`=4'hC, `CHAN_AT`=4'hD, `PITCH`=4'hE);
  - function `midi_data_len(status)` returning 0/1/2.
- No sub-module; classification stays combinational inside the block.

## Test plan
- 0x90, 0x3C, 0x64 on consecutive clocks → one `msg_valid` one cycle after the last byte with {0x90, 0x3C, 0x64}, and no `msg_err`.
- Running status: 0x90, 0x3C, 0x64, 0x40, 0x50 → two messages: {0x90, 0x3C, 0x64} and {0x90, 0x40, 0x50}.
- Real-time interleave: 0x91, 0xF8, 0x30, 0xFE, 0x7F → single message {0x91, 0x30, 0x7F}; no state disturbance.
- Abandon: 0x80, 0x3C, 0xC2, 0x05 → `msg_err` pulse on 0xC2, then {0xC2, 0x05, 0x00}. A following 0x07 → {0xC2, 0x07, 0x00}.
- SysEx: 0xF0, 0x7E, 0x01, 0xF7, 0x10 → no `msg_valid`, no `msg_err`. A leading stray 0x10 after reset → `msg_err` only.
- `MIDI_VEL0_NOTEOFF_EN` defined: 0x93, 0x3C, 0x00 → {0x83, 0x3C, 0x40}. With `OMNI`=0, `CHANNEL`=2, the same input → no output.
